// File: rtl/axi_lite_to_reg_bridge.sv
// AXI4-Lite slave to register-bus master bridge: one-entry buffer per AXI
// request channel, one register access in flight, errors returned as SLVERR.
package axi_lite_to_reg_bridge_pkg;
  localparam int unsigned ADDR_W = 48;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
  } axi_lite_ax_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } axi_lite_w_t;

  typedef struct packed {
    logic [1:0] resp;
  } axi_lite_b_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
  } axi_lite_r_t;

  typedef struct packed {
    axi_lite_ax_t aw;
    logic         aw_valid;
    axi_lite_w_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_lite_ax_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_lite_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    axi_lite_b_t b;
    logic        b_valid;
    logic        ar_ready;
    axi_lite_r_t r;
    logic        r_valid;
  } axi_lite_rsp_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              valid;
  } reg_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              error;
    logic              ready;
  } reg_rsp_t;

  // Encoding exposed on dbg_state_o.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_ACCESS = 3'd1,
    ST_RD_ACCESS = 3'd2,
    ST_WR_RESP   = 3'd3,
    ST_RD_RESP   = 3'd4
  } state_e;
endpackage

module axi_lite_to_reg_bridge #(
  parameter int unsigned ADDR_WIDTH = 48,
  parameter int unsigned DATA_WIDTH = 32,
  parameter type axi_lite_req_t = axi_lite_to_reg_bridge_pkg::axi_lite_req_t,
  parameter type axi_lite_rsp_t = axi_lite_to_reg_bridge_pkg::axi_lite_rsp_t,
  parameter type reg_req_t      = axi_lite_to_reg_bridge_pkg::reg_req_t,
  parameter type reg_rsp_t      = axi_lite_to_reg_bridge_pkg::reg_rsp_t
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  axi_lite_req_t axi_lite_req_i,
  output axi_lite_rsp_t axi_lite_rsp_o,
  output reg_req_t      reg_req_o,
  input  reg_rsp_t      reg_rsp_i,
  output logic [2:0]    dbg_state_o
);
  import axi_lite_to_reg_bridge_pkg::state_e;
  import axi_lite_to_reg_bridge_pkg::ST_IDLE;
  import axi_lite_to_reg_bridge_pkg::ST_WR_ACCESS;
  import axi_lite_to_reg_bridge_pkg::ST_RD_ACCESS;
  import axi_lite_to_reg_bridge_pkg::ST_WR_RESP;
  import axi_lite_to_reg_bridge_pkg::ST_RD_RESP;

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  // Handshakes on every channel: a beat transfers on a rising edge where valid
  // and ready are both high; a source holds valid and payload until then, and
  // every ready driven here comes from registered state only.
  state_e                  state_q,   state_d;
  logic                    prio_rd_q, prio_rd_d;
  logic                    aw_full_q, aw_full_d;
  logic                    w_full_q,  w_full_d;
  logic                    ar_full_q, ar_full_d;
  logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
  logic [DATA_WIDTH-1:0]   w_data_q,  w_data_d;
  logic [STRB_WIDTH-1:0]   w_strb_q,  w_strb_d;
  logic [ADDR_WIDTH-1:0]   ar_addr_q, ar_addr_d;
  logic                    err_q,     err_d;
  logic [DATA_WIDTH-1:0]   rdata_q,   rdata_d;

  logic aw_hs, w_hs, ar_hs;
  logic wr_elig, rd_elig;

  always_comb begin
    aw_hs = axi_lite_req_i.aw_valid & ~aw_full_q;
    w_hs  = axi_lite_req_i.w_valid  & ~w_full_q;
    ar_hs = axi_lite_req_i.ar_valid & ~ar_full_q;
    // A beat arriving this cycle counts, so IDLE reaches ACCESS one cycle after the handshake.
    wr_elig = (aw_full_q | aw_hs) & (w_full_q | w_hs);
    rd_elig = ar_full_q | ar_hs;

    state_d   = state_q;
    prio_rd_d = prio_rd_q;
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    ar_full_d = ar_full_q;
    aw_addr_d = aw_addr_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    ar_addr_d = ar_addr_q;
    err_d     = err_q;
    rdata_d   = rdata_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = axi_lite_req_i.aw.addr;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = axi_lite_req_i.w.data;
      w_strb_d = axi_lite_req_i.w.strb;
    end
    if (ar_hs) begin
      ar_full_d = 1'b1;
      ar_addr_d = axi_lite_req_i.ar.addr;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (wr_elig && rd_elig) begin
          state_d   = prio_rd_q ? ST_RD_ACCESS : ST_WR_ACCESS;
          prio_rd_d = ~prio_rd_q;
        end else if (wr_elig) begin
          state_d = ST_WR_ACCESS;
        end else if (rd_elig) begin
          state_d = ST_RD_ACCESS;
        end
      end
      ST_WR_ACCESS: begin
        if (reg_rsp_i.ready) begin
          err_d   = reg_rsp_i.error;
          state_d = ST_WR_RESP;
        end
      end
      ST_RD_ACCESS: begin
        if (reg_rsp_i.ready) begin
          err_d   = reg_rsp_i.error;
          rdata_d = reg_rsp_i.rdata;
          state_d = ST_RD_RESP;
        end
      end
      ST_WR_RESP: begin
        if (axi_lite_req_i.b_ready) begin
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_RD_RESP: begin
        if (axi_lite_req_i.r_ready) begin
          ar_full_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      prio_rd_q <= 1'b0;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      ar_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_addr_q <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      prio_rd_q <= prio_rd_d;
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      ar_full_q <= ar_full_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      ar_addr_q <= ar_addr_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // Every output is a function of registered state, so payloads stay stable while waiting.
  always_comb begin
    axi_lite_rsp_o          = '0;
    axi_lite_rsp_o.aw_ready = ~aw_full_q;
    axi_lite_rsp_o.w_ready  = ~w_full_q;
    axi_lite_rsp_o.ar_ready = ~ar_full_q;
    axi_lite_rsp_o.b_valid  = (state_q == ST_WR_RESP);
    axi_lite_rsp_o.b.resp   = ((state_q == ST_WR_RESP) && err_q) ? 2'b10 : 2'b00;
    axi_lite_rsp_o.r_valid  = (state_q == ST_RD_RESP);
    axi_lite_rsp_o.r.resp   = ((state_q == ST_RD_RESP) && err_q) ? 2'b10 : 2'b00;
    axi_lite_rsp_o.r.data   = rdata_q;
  end

  always_comb begin
    reg_req_o = '0;
    if (state_q == ST_WR_ACCESS) begin
      reg_req_o.valid = 1'b1;
      reg_req_o.write = 1'b1;
      reg_req_o.addr  = aw_addr_q;
      reg_req_o.wdata = w_data_q;
      reg_req_o.wstrb = w_strb_q;
    end else if (state_q == ST_RD_ACCESS) begin
      reg_req_o.valid = 1'b1;
      reg_req_o.addr  = ar_addr_q;
    end
  end

  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_axi_lite_to_reg_bridge.sv
// Bench for axi_lite_to_reg_bridge: directed protocol scenarios plus random
// single transactions checked against a memory-level reference model.
module tb_axi_lite_to_reg_bridge;
  import axi_lite_to_reg_bridge_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  axi_lite_req_t req;
  axi_lite_rsp_t rsp;
  reg_req_t      rreq;
  reg_rsp_t      rrsp;
  logic [2:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [33:0] exp_q[$];
  logic [31:0] ref_mem    [logic [47:0]];
  logic [31:0] periph_mem [logic [47:0]];
  logic [47:0] pool [4];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500us");
    $fatal(1, "watchdog");
  end

  axi_lite_to_reg_bridge dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .axi_lite_req_i (req),
    .axi_lite_rsp_o (rsp),
    .reg_req_o      (rreq),
    .reg_rsp_i      (rrsp),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Reference model: AXI-level memory; a failed write leaves it unchanged.
  task automatic expect_wr(input logic [47:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit err);
    logic [31:0] old;
    old = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    if (!err) ref_mem[a] = merge(old, d, s);
    exp_q.push_back({(err ? 2'b10 : 2'b00), 32'h0});
  endtask

  task automatic expect_rd(input logic [47:0] a, input bit err);
    logic [31:0] v;
    v = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    exp_q.push_back({(err ? 2'b10 : 2'b00), v});
  endtask

  task automatic reset_dut();
    req  = '0;
    rrsp = '0;
    rst  = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- driver: register peripheral + AXI response side ----------------
  task automatic service(input bit is_wr, input logic [47:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int max_wait, input int waits,
                         input bit err, input int resp_dly);
    int          t;
    reg_req_t    held;
    logic [33:0] exp;
    logic [33:0] obs;
    logic [31:0] old;
    t   = 0;
    exp = exp_q.pop_front();
    while (!rreq.valid && t < max_wait) begin
      tick();
      t++;
    end
    check("req_valid", 128'(rreq.valid), 128'(1));
    if (!rreq.valid) return;
    check("req_write", 128'(rreq.write), 128'(is_wr));
    check("req_addr",  128'(rreq.addr),  128'(a));
    check("req_wdata", 128'(rreq.wdata), 128'(is_wr ? d : 32'h0));
    check("req_wstrb", 128'(rreq.wstrb), 128'(is_wr ? s : 4'h0));
    held = rreq;
    for (int i = 0; i < waits; i++) begin
      rrsp.rdata = $urandom;
      rrsp.error = 1'($urandom);
      tick();
      check("req_stable", 128'(rreq), 128'(held));
    end
    old        = periph_mem.exists(a) ? periph_mem[a] : 32'h0;
    rrsp.ready = 1'b1;
    rrsp.error = err;
    rrsp.rdata = is_wr ? $urandom : old;
    if (is_wr && !err) periph_mem[a] = merge(old, d, s);
    tick();
    rrsp.ready = 1'b0;
    rrsp.error = 1'($urandom);
    rrsp.rdata = $urandom;
    check("req_released", 128'(rreq.valid), 128'(0));
    check(is_wr ? "b_valid" : "r_valid", 128'(is_wr ? rsp.b_valid : rsp.r_valid), 128'(1));
    obs = is_wr ? {rsp.b.resp, 32'h0} : {rsp.r.resp, rsp.r.data};
    check(is_wr ? "b_payload" : "r_payload", 128'(obs), 128'(exp));
    for (int i = 0; i < resp_dly; i++) begin
      tick();
      obs = is_wr ? {rsp.b.resp, 32'h0} : {rsp.r.resp, rsp.r.data};
      check("resp_valid_held", 128'(is_wr ? rsp.b_valid : rsp.r_valid), 128'(1));
      check("resp_stable", 128'(obs), 128'(exp));
    end
    if (is_wr) req.b_ready = 1'b1;
    else       req.r_ready = 1'b1;
    tick();
    req.b_ready = 1'b0;
    req.r_ready = 1'b0;
    check("resp_dropped", 128'(is_wr ? rsp.b_valid : rsp.r_valid), 128'(0));
    if (is_wr) check("aw_w_freed", 128'({rsp.aw_ready, rsp.w_ready}), 128'(2'b11));
    else       check("ar_freed", 128'(rsp.ar_ready), 128'(1));
  endtask

  // ---------------- driver: AXI request beats ----------------
  task automatic xact(input bit is_wr, input logic [47:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int aw_dly, input int w_dly, input int waits,
                      input bit err, input int resp_dly);
    bit aw_left, w_left, ar_left, aw_hs, w_hs, ar_hs;
    int t;
    aw_left = is_wr;
    w_left  = is_wr;
    ar_left = !is_wr;
    t       = 0;
    if (is_wr) expect_wr(a, d, s, err);
    else       expect_rd(a, err);
    while ((aw_left || w_left || ar_left) && t < 20) begin
      if (aw_left && t >= aw_dly) begin req.aw_valid = 1'b1; req.aw.addr = a; end
      if (w_left && t >= w_dly) begin req.w_valid = 1'b1; req.w.data = d; req.w.strb = s; end
      if (ar_left && t >= aw_dly) begin req.ar_valid = 1'b1; req.ar.addr = a; end
      aw_hs = req.aw_valid && rsp.aw_ready;
      w_hs  = req.w_valid && rsp.w_ready;
      ar_hs = req.ar_valid && rsp.ar_ready;
      tick();
      if (aw_hs) begin aw_left = 1'b0; req.aw_valid = 1'b0; end
      if (w_hs)  begin w_left  = 1'b0; req.w_valid  = 1'b0; end
      if (ar_hs) begin ar_left = 1'b0; req.ar_valid = 1'b0; end
      if (aw_left || w_left || ar_left) check("no_early_req", 128'(rreq.valid), 128'(0));
      if (is_wr && !w_left && aw_left) check("w_ready_held", 128'(rsp.w_ready), 128'(0));
      if (is_wr && !aw_left && w_left) check("aw_ready_held", 128'(rsp.aw_ready), 128'(0));
      t++;
    end
    check("beats_accepted", 128'(aw_left || w_left || ar_left), 128'(0));
    service(is_wr, a, d, s, 0, waits, err, resp_dly);
  endtask

  // AW, W and AR presented in the same cycle; the arbiter picks the order.
  task automatic collide(input bit write_first);
    logic [47:0] wa, ra;
    logic [31:0] d;
    logic [3:0]  s;
    bit          we, re;
    wa = pool[$urandom_range(0, 3)];
    ra = pool[$urandom_range(0, 3)];
    d  = $urandom;
    s  = 4'($urandom);
    we = 1'($urandom);
    re = 1'($urandom);
    req.aw_valid = 1'b1; req.aw.addr = wa;
    req.w_valid  = 1'b1; req.w.data = d; req.w.strb = s;
    req.ar_valid = 1'b1; req.ar.addr = ra;
    tick();
    req.aw_valid = 1'b0;
    req.w_valid  = 1'b0;
    req.ar_valid = 1'b0;
    check("arb_ar_buffered", 128'(rsp.ar_ready), 128'(0));
    check("arb_aw_buffered", 128'(rsp.aw_ready), 128'(0));
    if (write_first) begin
      expect_wr(wa, d, s, we);
      expect_rd(ra, re);
      service(1'b1, wa, d, s, 0, 0, we, 0);
      service(1'b0, ra, 32'h0, 4'h0, 2, 1, re, 0);
    end else begin
      expect_rd(ra, re);
      expect_wr(wa, d, s, we);
      service(1'b0, ra, 32'h0, 4'h0, 0, 0, re, 0);
      service(1'b1, wa, d, s, 2, 1, we, 0);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    req  = '0;
    rrsp = '0;
    for (int i = 0; i < 4; i++) pool[i] = {16'($urandom), $urandom};
    repeat (2) @(posedge clk);
    #1;
    check("rst_readies", 128'({rsp.aw_ready, rsp.w_ready, rsp.ar_ready}), 128'(3'b111));
    check("rst_b_valid", 128'(rsp.b_valid), 128'(0));
    check("rst_r_valid", 128'(rsp.r_valid), 128'(0));
    check("rst_resp_data", 128'({rsp.b.resp, rsp.r.resp, rsp.r.data}), 128'(0));
    check("rst_reg_req", 128'(rreq), 128'(0));
    check("rst_state_idle", 128'(dbg_state), 128'(ST_IDLE));
    rst = 1'b0;

    // Single write with immediate ready.
    xact(1'b1, 48'h1000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 1'b0, 0);
    // Read with three wait states.
    ref_mem[48'h2004]    = 32'h1234_5678;
    periph_mem[48'h2004] = 32'h1234_5678;
    xact(1'b0, 48'h2004, 32'h0, 4'h0, 0, 0, 3, 1'b0, 1);
    // Error mapping on write and read.
    xact(1'b1, 48'h3000, 32'hCAFE_F00D, 4'h5, 0, 0, 0, 1'b1, 0);
    xact(1'b0, 48'h2004, 32'h0, 4'h0, 0, 0, 1, 1'b1, 2);
    // W four cycles ahead of AW; unaligned address and all-zero strobe pass through.
    xact(1'b1, 48'h4000_0000_0001, 32'h0BAD_CAFE, 4'h0, 4, 0, 0, 1'b0, 0);
    // AW three cycles ahead of W.
    xact(1'b1, 48'h2004, 32'hA5A5_5A5A, 4'h6, 0, 3, 2, 1'b0, 0);
    xact(1'b0, 48'h2004, 32'h0, 4'h0, 0, 0, 0, 1'b0, 0);

    // Random single transactions.
    for (int k = 0; k < 40; k++) begin
      xact(1'($urandom), pool[$urandom_range(0, 3)], $urandom, 4'($urandom),
           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
           ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
    end

    // Arbitration from reset: write, then read; then read, then write; then write again.
    reset_dut();
    collide(1'b1);
    collide(1'b0);
    collide(1'b1);

    // Reset during a read access.
    req.ar_valid = 1'b1;
    req.ar.addr  = pool[0];
    tick();
    req.ar_valid = 1'b0;
    check("mid_rst_access", 128'(rreq.valid), 128'(1));
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_withdrawn", 128'(rreq.valid), 128'(0));
    check("mid_rst_readies", 128'({rsp.aw_ready, rsp.w_ready, rsp.ar_ready}), 128'(3'b111));
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_r", 128'(rsp.r_valid), 128'(0));
      check("post_rst_no_req", 128'(rreq.valid), 128'(0));
    end
    check("post_rst_state_idle", 128'(dbg_state), 128'(ST_IDLE));
    // Priority was "read" before the reset; reset restores write-first.
    collide(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
